// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 transmit states, frame constants and command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam int PS2_FRAME_FE = 11;
    localparam int PS2_PARITY_W = 1;
    localparam int PS2_SHIFT_W  = 8 + PS2_PARITY_W;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    // Odd parity sits above the data byte so the frame shifts out LSB first.
    function automatic logic [PS2_SHIFT_W-1:0] ps2_frame_load(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - ps2 clock/data synchronizer with falling-edge strobe
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic ps2_clk_raw,
    input  logic ps2_data_raw,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] data_pipe;
    logic                   clk_prev;

    // Reset to the idle-high line level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], ps2_clk_raw};
            data_pipe <= {data_pipe[SYNC_STAGES-2:0], ps2_data_raw};
            clk_prev  <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign clk_sync  = clk_pipe[SYNC_STAGES-1];
    assign data_sync = data_pipe[SYNC_STAGES-1];
    assign clk_fe    = clk_prev & ~clk_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clk_T,
    input  logic       Reset_T,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_e             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [3:0]             bitcnt, bitcnt_n;
    logic [PS2_SHIFT_W-1:0] shift, shift_n;
    logic                   clk_oe_n, data_oe_n, busy_n;
    logic                   clk_sync, data_sync, clk_fe, timed_out;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk          (Clk_T),
        .resetn       (Reset_T),
        .ps2_clk_raw  (ps2_clk_in),
        .ps2_data_raw (ps2_data_in),
        .clk_sync     (clk_sync),
        .data_sync    (data_sync),
        .clk_fe       (clk_fe)
    );

    always_ff @(posedge Clk_T) begin
        if (!Reset_T) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            shift       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bitcnt      <= bitcnt_n;
            shift       <= shift_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_busy     <= busy_n;
            tx_done     <= (state_n == DONE);
            tx_err      <= (state_n == ERR);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bitcnt_n  = bitcnt;
        shift_n   = shift;
        data_oe_n = ps2_data_oe;
        timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_start) begin
                    shift_n  = ps2_frame_load(tx_data);
                    bitcnt_n = '0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = REQ;
                end
            end
            REQ: begin
                if (clk_fe) begin
                    cnt_n     = '0;
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b1, shift[PS2_SHIFT_W-1:1]};
                    bitcnt_n  = 4'd1;
                    state_n   = DATA;
                end else if (timed_out) begin
                    state_n = ERR;
                end
            end
            DATA: begin
                if (clk_fe) begin
                    cnt_n    = '0;
                    bitcnt_n = bitcnt + 1'b1;
                    // Once the parity bit is out, the next edge is the released stop bit.
                    if (bitcnt == 4'(PS2_SHIFT_W)) begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~shift[0];
                        shift_n   = {1'b1, shift[PS2_SHIFT_W-1:1]};
                    end
                end else if (timed_out) begin
                    state_n = ERR;
                end
            end
            ACK: begin
                if (clk_fe) begin
                    cnt_n    = '0;
                    bitcnt_n = 4'(PS2_FRAME_FE);
                    state_n  = data_sync ? ERR : WAIT_IDLE;
                end else if (timed_out) begin
                    state_n = ERR;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_n = DONE;
                end else if (clk_fe) begin
                    cnt_n = '0;
                end else if (timed_out) begin
                    state_n = ERR;
                end
            end
            DONE, ERR: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        clk_oe_n = (state_n == INHIBIT);
        if (state_n inside {IDLE, INHIBIT, DONE, ERR}) begin
            data_oe_n = 1'b0;
        end
        busy_n = state_n inside {INHIBIT, REQ, DATA, ACK, WAIT_IDLE};
    end

endmodule
